// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Used by both the receive and transmit sides so the state encoding and
// the default baud divisor stay in one place.
package uart_pkg;

    // 12 MHz core clock / 115200 baud, rounded.
    localparam int DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side result bundle: received byte plus status pulses.
// Latency: n/a (wires only).
// Backpressure: none; the consumer must take DATA on the VALID cycle.
//
// DATA      last correctly received byte
// VALID     one-cycle pulse, DATA updated this cycle
// FRAME_ERR one-cycle pulse, stop bit sampled low
// BUSY      receiver is somewhere other than IDLE
interface uart_rx_if;
    logic [7:0] DATA;
    logic       VALID;
    logic       FRAME_ERR;
    logic       BUSY;

    modport master (output DATA, output VALID, output FRAME_ERR, output BUSY);
    modport slave  (input  DATA, input  VALID, input  FRAME_ERR, input  BUSY);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Latency: 2 clk cycles from d to q.
// Backpressure: none.
//
// clk   destination clock
// rst_n asynchronous active-low reset; both flops load RESET_VAL
// d     asynchronous input
// q     synchronized output
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and frame-error detection.
// Latency: VALID about 9.5 bit periods + 3 clk after the RX falling edge.
// Backpressure: none; each byte is presented for one cycle on VALID.
//
// CLK   system clock, rising edge
// RST   asynchronous active-low reset
// RX    serial line, idle high, asynchronous to CLK
// out   DATA / VALID / FRAME_ERR / BUSY (see uart_rx_if)
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      RX,
    uart_rx_if.master out
);

    // Terminal counts; the counter restarts from 0 at every sample point.
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    logic        rx_s;
    uart_state_t state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        ferr_q;

    // Reset value 1 so a reset never looks like a start bit.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (RX),
        .q     (rx_s)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end

                // Wait half a bit and re-check the line: a high sample here
                // means the falling edge was a glitch, so drop it silently.
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // Now aligned to mid-bit: one sample per full bit period.
                ST_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // Leaving at mid-stop (not end of stop) lets the next start
                // bit be caught even with zero idle time between frames.
                ST_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end

                // Line held low (break); a new frame cannot start until the
                // line has gone idle again.
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out.DATA      = data_q;
    assign out.VALID     = valid_q;
    assign out.FRAME_ERR = ferr_q;
    assign out.BUSY      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 104;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RX  = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .RX  (RX),
        .out (bus)
    );

    // ~12 MHz
    always #41.667 CLK = ~CLK;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         valid_cycs[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_fall = 0;
    logic [7:0] model_data = 8'h00;

    always @(posedge CLK) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference: a well-formed 8N1 frame yields exactly that byte.
    task automatic send_frame(input logic [7:0] b);
        sb.push_back('{is_err: 1'b0, data: b});
        last_fall = cyc;
        RX = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            wait_cycles(CPB);
        end
        RX = 1'b1;
        wait_cycles(CPB);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("drain_in_time", sb.size(), 0);
    endtask

    // Monitor: every status pulse must match the head of the scoreboard.
    initial begin
        logic prev_p;
        exp_t e;
        prev_p = 1'b0;
        forever begin
            @(negedge CLK);
            if (bus.VALID || bus.FRAME_ERR) begin
                check("valid_ferr_exclusive", int'(bus.VALID & bus.FRAME_ERR), 0);
                check("pulse_one_cycle", int'(prev_p), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: VALID=%0b FRAME_ERR=%0b DATA=%h, none expected",
                             bus.VALID, bus.FRAME_ERR, bus.DATA);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind_ferr", int'(bus.FRAME_ERR), int'(e.is_err));
                    if (!e.is_err) model_data = e.data;
                    check("data", int'(bus.DATA), int'(model_data));
                end
                if (bus.VALID) valid_cycs.push_back(cyc);
            end
            prev_p = bus.VALID | bus.FRAME_ERR;
        end
    end

    initial begin
        int n0;
        int busy_cnt;
        int gap;
        logic [7:0] b;
        logic [7:0] c5;

        #1 RST = 1'b0;
        #49;
        check("rst_data", int'(bus.DATA), 0);
        check("rst_valid", int'(bus.VALID), 0);
        check("rst_ferr", int'(bus.FRAME_ERR), 0);
        check("rst_busy", int'(bus.BUSY), 0);
        #50 RST = 1'b1;
        wait_cycles(20);

        // Single frame, plus first-byte latency from the RX falling edge.
        n0 = valid_cycs.size();
        send_frame(8'hF0);
        wait_drain(2000);
        if (valid_cycs.size() == n0 + 1)
            check_range("latency", valid_cycs[n0] - last_fall, 985, 997);
        else
            check("f0_valid_count", valid_cycs.size() - n0, 1);

        // Back-to-back frames, zero idle bits.
        wait_cycles(30);
        n0 = valid_cycs.size();
        send_frame(8'h55);
        send_frame(8'hA3);
        wait_drain(2000);
        if (valid_cycs.size() == n0 + 2)
            check_range("b2b_spacing", valid_cycs[n0 + 1] - valid_cycs[n0], 1038, 1042);
        else
            check("b2b_valid_count", valid_cycs.size() - n0, 2);

        // 8'h00 with the stop bit held low for 3 bit periods.
        wait_cycles(30);
        sb.push_back('{is_err: 1'b1, data: 8'h00});
        RX = 1'b0;
        wait_cycles(CPB * 12);
        check("ferr_seen", sb.size(), 0);
        check("busy_while_low", int'(bus.BUSY), 1);
        check("data_kept", int'(bus.DATA), 8'hA3);
        RX = 1'b1;
        wait_cycles(6);
        check("idle_after_release", int'(bus.BUSY), 0);
        wait_cycles(CPB);

        // 40-cycle glitch on an idle line.
        busy_cnt = 0;
        RX = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i == 40) RX = 1'b1;
            @(negedge CLK);
            if (bus.BUSY) busy_cnt++;
        end
        check_range("glitch_busy_len", busy_cnt, 48, 56);
        check("glitch_idle", int'(bus.BUSY), 0);

        // Reset during data bit 4 of 8'hC5: no pulse, then a clean frame.
        c5 = 8'hC5;
        RX = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            RX = c5[i];
            wait_cycles(CPB);
        end
        RX = c5[4];
        wait_cycles(CPB / 2);
        RST = 1'b0;
        RX  = 1'b1;
        model_data = 8'h00;
        wait_cycles(3);
        check("midrst_data", int'(bus.DATA), 0);
        check("midrst_valid", int'(bus.VALID), 0);
        check("midrst_ferr", int'(bus.FRAME_ERR), 0);
        check("midrst_busy", int'(bus.BUSY), 0);
        wait_cycles(5);
        RST = 1'b1;
        wait_cycles(CPB * 2);
        check("no_pulse_after_abort", sb.size(), 0);
        send_frame(8'h3C);
        wait_drain(2000);
        check("data_3c", int'(bus.DATA), 8'h3C);

        // Random bytes with random idle gaps (including zero).
        for (int k = 0; k < 8; k++) begin
            b   = 8'($urandom);
            gap = $urandom_range(0, 300);
            wait_cycles(gap);
            send_frame(b);
        end
        wait_drain(2000);

        wait_cycles(CPB * 2);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
